// File: rtl/full_adder_4_pkg.sv
// rtl/full_adder_4_pkg.sv - shared constants for the registered ripple-carry adder
package full_adder_4_pkg;

  // Default operand width of the adder datapath
  localparam int FA_WIDTH = 4;

endpackage

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - one-bit combinational full adder cell
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic a_xor_b;

  // Propagate term is shared by the sum and the carry logic
  always_comb begin
    a_xor_b = a ^ b;
    sum     = a_xor_b ^ c_in;
    c_out   = (a & b) | (c_in & a_xor_b);
  end

endmodule

// File: rtl/full_adder_4.sv
// rtl/full_adder_4.sv - ripple-carry adder with registered {carry,sum} result
module full_adder_4
  import full_adder_4_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Carry chain: chain[0] is the carry-in, chain[WIDTH] the carry-out
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   result_d;
  logic [WIDTH:0]   result_q;

  assign chain[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_1bit u_bit (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (chain[i]),
      .sum   (sum_c[i]),
      .c_out (chain[i+1])
    );
  end

  // Full-width result of the combinational chain, carry in the MSB
  always_comb begin
    result_d = {chain[WIDTH], sum_c};
  end

  // Output register; reset wins over the operand update at the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign sum   = result_q[WIDTH-1:0];
  assign carry = result_q[WIDTH];

endmodule

// File: tb/tb_full_adder_4.sv
// tb/tb_full_adder_4.sv - self-checking bench for full_adder_4
module tb_full_adder_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       carry;

  int checks;
  int failures;

  full_adder_4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the plain arithmetic value the register must hold after an edge
  function automatic logic [4:0] model(input logic r, input logic [3:0] x,
                                       input logic [3:0] y, input logic ci);
    int total;
    total = int'(x) + int'(y) + int'(ci);
    return r ? 5'(total) : 5'd0;
  endfunction

  // Present inputs away from the edge, clock them in, settle past the edge
  task automatic drive(input logic r, input logic [3:0] x, input logic [3:0] y,
                       input logic ci);
    @(negedge clk);
    rst_n = r;
    a     = x;
    b     = y;
    c_in  = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'hF, 4'hF, 1'b1);
      checks++;
      if ({carry, sum} !== 5'd0) begin
        failures++;
        $display("FAIL reset edge %0d: got %0d expected 0", i, {carry, sum});
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] va [6] = '{4'd3, 4'd5, 4'd9, 4'd7, 4'd15, 4'd15};
    logic [3:0] vb [6] = '{4'd4, 4'd9, 4'd9, 4'd8, 4'd15, 4'd0};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] ex [6] = '{5'd7, 5'd14, 5'd18, 5'd15, 5'd31, 5'd16};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      checks++;
      if ({carry, sum} !== ex[i]) begin
        failures++;
        $display("FAIL basic %0d+%0d+%0d: got %0d expected %0d",
                 va[i], vb[i], vc[i], {carry, sum}, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd3, 4'd4, 1'b0);
    checks++;
    if ({carry, sum} !== 5'd7) begin
      failures++;
      $display("FAIL b2b first: got %0d expected 7", {carry, sum});
    end
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    checks++;
    if (carry !== 1'b1 || sum !== 4'd2) begin
      failures++;
      $display("FAIL b2b second: got carry=%0b sum=%0d expected carry=1 sum=2", carry, sum);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'd5, 4'd6, 1'b0);
    drive(1'b0, 4'd9, 4'd9, 1'b0);
    checks++;
    if ({carry, sum} !== 5'd0) begin
      failures++;
      $display("FAIL midreset assert: got %0d expected 0", {carry, sum});
    end
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    checks++;
    if (carry !== 1'b1 || sum !== 4'd2) begin
      failures++;
      $display("FAIL midreset release: got carry=%0b sum=%0d expected carry=1 sum=2", carry, sum);
    end
  endtask

  task automatic test_hold();
    logic [4:0] held;
    drive(1'b1, 4'd12, 4'd11, 1'b1);
    held = {carry, sum};
    // Change inputs mid-cycle; the registered output must not follow them
    #2;
    a = 4'd0;
    b = 4'd0;
    c_in = 1'b0;
    #1;
    checks++;
    if ({carry, sum} !== model(1'b1, 4'd12, 4'd11, 1'b1) || held !== 5'd24) begin
      failures++;
      $display("FAIL hold: got %0d expected 24", {carry, sum});
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] expv;
    for (int v = 0; v < 512; v++) begin
      drive(1'b1, 4'(v[3:0]), 4'(v[7:4]), v[8]);
      expv = model(1'b1, 4'(v[3:0]), 4'(v[7:4]), v[8]);
      checks++;
      if ({carry, sum} !== expv) begin
        failures++;
        $display("FAIL exhaustive a=%0d b=%0d c_in=%0d: got %0d expected %0d",
                 v[3:0], v[7:4], v[8], {carry, sum}, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] x;
    logic [3:0] y;
    logic       ci;
    logic       r;
    logic [4:0] expv;
    for (int i = 0; i < 300; i++) begin
      x  = 4'($urandom_range(0, 15));
      y  = 4'($urandom_range(0, 15));
      ci = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 9) != 0);
      drive(r, x, y, ci);
      expv = model(r, x, y, ci);
      checks++;
      if ({carry, sum} !== expv) begin
        failures++;
        $display("FAIL random rst_n=%0b a=%0d b=%0d c_in=%0d: got %0d expected %0d",
                 r, x, y, ci, {carry, sum}, expv);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = 4'hF;
    b        = 4'hF;
    c_in     = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midstream();
    test_hold();
    test_exhaustive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
